// File: rtl/ipbus_pkt_buffer.sv
// Single-packet request/reply buffer placed in front of the IPbus transactor.
// Collects one request packet into rx_ram, exposes it through the packet-buffer
// read port, captures reply writes into tx_ram and streams the reply out.
module ipbus_pkt_buffer #(
    parameter int unsigned ADDRWID = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [31:0]        rx_data,
    input  logic               rx_last,
    output logic               rx_ready,
    output logic               rx_drop,
    output logic               pkt_rdy,
    output logic               pkt_busy,
    input  logic [ADDRWID-1:0] pkt_raddr,
    output logic [31:0]        pkt_rdata,
    input  logic               pkt_we,
    input  logic [ADDRWID-1:0] pkt_waddr,
    input  logic [31:0]        pkt_wdata,
    input  logic               pkt_done,
    output logic               tx_valid,
    output logic [31:0]        tx_data,
    output logic               tx_last,
    input  logic               tx_ready
);

    localparam int unsigned DEPTH  = 1 << ADDRWID;
    localparam int unsigned LEN_W  = ADDRWID + 1;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2,
        DRAIN = 2'd3
    } state_t;

    logic [DATA_W-1:0]  rx_ram [DEPTH];
    logic [DATA_W-1:0]  tx_ram [DEPTH];

    state_t             state_q, state_d;
    logic               discard_q, discard_d;
    logic [ADDRWID-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDRWID-1:0] rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]   reply_len_q, reply_len_d;
    logic               rx_ready_q, rx_ready_d;
    logic               rx_drop_q, rx_drop_d;
    logic               pkt_rdy_q, pkt_rdy_d;
    logic               pkt_busy_q, pkt_busy_d;
    logic               tx_valid_q, tx_valid_d;
    logic               tx_last_q, tx_last_d;
    logic [DATA_W-1:0]  tx_data_q;
    logic [DATA_W-1:0]  pkt_rdata_q;

    logic               rx_beat_c;
    logic               rx_we_c;
    logic               tx_we_c;
    logic               tx_load_c;
    logic [ADDRWID-1:0] tx_raddr_c;
    logic [LEN_W-1:0]   waddr_len_c;

    // Next-state, counters and strobes for the request/reply sequence.
    always_comb begin
        state_d     = state_q;
        discard_d   = discard_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        reply_len_d = reply_len_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        rx_drop_d   = 1'b0;
        rx_we_c     = 1'b0;
        tx_we_c     = 1'b0;
        tx_load_c   = 1'b0;
        tx_raddr_c  = rd_cnt_q;
        rx_beat_c   = rx_valid & rx_ready_q;
        waddr_len_c = {1'b0, pkt_waddr} + LEN_W'(1);

        case (state_q)
            IDLE, FILL: begin
                if (rx_beat_c) begin
                    if (discard_q) begin
                        // Overflowed packet: swallow words until its last beat.
                        if (rx_last) begin
                            state_d   = IDLE;
                            discard_d = 1'b0;
                            wr_cnt_d  = '0;
                            rx_drop_d = 1'b1;
                        end
                    end else begin
                        rx_we_c = 1'b1;
                        if (rx_last) begin
                            state_d     = READY;
                            wr_cnt_d    = '0;
                            reply_len_d = '0;
                        end else begin
                            state_d = FILL;
                            if (wr_cnt_q == '1) begin
                                discard_d = 1'b1;
                                wr_cnt_d  = '0;
                            end else begin
                                wr_cnt_d = wr_cnt_q + ADDRWID'(1);
                            end
                        end
                    end
                end
            end
            READY: begin
                if (pkt_we) begin
                    tx_we_c = 1'b1;
                    if (waddr_len_c > reply_len_q) begin
                        reply_len_d = waddr_len_c;
                    end
                end
                if (pkt_done) begin
                    if (reply_len_d == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DRAIN;
                        rd_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (!tx_valid_q) begin
                    // Prefetch cycle: fetch word 0 into the output register.
                    tx_load_c  = 1'b1;
                    tx_raddr_c = rd_cnt_q;
                    tx_valid_d = 1'b1;
                    tx_last_d  = (reply_len_q == LEN_W'(1));
                end else if (tx_ready) begin
                    if (tx_last_q) begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                    end else begin
                        rd_cnt_d   = rd_cnt_q + ADDRWID'(1);
                        tx_raddr_c = rd_cnt_q + ADDRWID'(1);
                        tx_load_c  = 1'b1;
                        tx_last_d  = (({1'b0, rd_cnt_q} + LEN_W'(2)) == reply_len_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rx_ready_d = (state_d == IDLE) || (state_d == FILL);
        pkt_rdy_d  = (state_d == READY);
        pkt_busy_d = (state_d == DRAIN);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            discard_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            reply_len_q <= '0;
            rx_ready_q  <= 1'b0;
            rx_drop_q   <= 1'b0;
            pkt_rdy_q   <= 1'b0;
            pkt_busy_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            discard_q   <= discard_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            reply_len_q <= reply_len_d;
            rx_ready_q  <= rx_ready_d;
            rx_drop_q   <= rx_drop_d;
            pkt_rdy_q   <= pkt_rdy_d;
            pkt_busy_q  <= pkt_busy_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
        end
    end

    // Request RAM write port, fed by the incoming word stream.
    always_ff @(posedge clk) begin
        if (rx_we_c) begin
            rx_ram[wr_cnt_q] <= rx_data;
        end
    end

    // Request RAM read port for the transactor, one-cycle latency in all states.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_rdata_q <= '0;
        end else begin
            pkt_rdata_q <= rx_ram[pkt_raddr];
        end
    end

    // Reply RAM write port, only open while the request is presented.
    always_ff @(posedge clk) begin
        if (tx_we_c) begin
            tx_ram[pkt_waddr] <= pkt_wdata;
        end
    end

    // Reply output register; only reloaded on prefetch or accepted transfer so it holds under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q <= '0;
        end else if (tx_load_c) begin
            tx_data_q <= tx_ram[tx_raddr_c];
        end
    end

    assign rx_ready  = rx_ready_q;
    assign rx_drop   = rx_drop_q;
    assign pkt_rdy   = pkt_rdy_q;
    assign pkt_busy  = pkt_busy_q;
    assign pkt_rdata = pkt_rdata_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign tx_last   = tx_last_q;

endmodule

// File: tb/tb_ipbus_pkt_buffer.sv
// Self-checking bench for ipbus_pkt_buffer against a transaction-level model.
module tb_ipbus_pkt_buffer;

    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          rx_valid;
    logic [31:0]   rx_data;
    logic          rx_last;
    logic          rx_ready;
    logic          rx_drop;
    logic          pkt_rdy;
    logic          pkt_busy;
    logic [AW-1:0] pkt_raddr;
    logic [31:0]   pkt_rdata;
    logic          pkt_we;
    logic [AW-1:0] pkt_waddr;
    logic [31:0]   pkt_wdata;
    logic          pkt_done;
    logic          tx_valid;
    logic [31:0]   tx_data;
    logic          tx_last;
    logic          tx_ready;

    ipbus_pkt_buffer #(.ADDRWID(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_last   (rx_last),
        .rx_ready  (rx_ready),
        .rx_drop   (rx_drop),
        .pkt_rdy   (pkt_rdy),
        .pkt_busy  (pkt_busy),
        .pkt_raddr (pkt_raddr),
        .pkt_rdata (pkt_rdata),
        .pkt_we    (pkt_we),
        .pkt_waddr (pkt_waddr),
        .pkt_wdata (pkt_wdata),
        .pkt_done  (pkt_done),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: RAM images and the current reply length.
    logic [31:0] m_rx [DEPTH];
    logic [31:0] m_tx [DEPTH];
    bit          m_tx_known [DEPTH];
    int          m_len;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
        check({tag, "_rx_drop"},   32'(rx_drop),   32'd0);
        check({tag, "_pkt_rdy"},   32'(pkt_rdy),   32'd0);
        check({tag, "_pkt_busy"},  32'(pkt_busy),  32'd0);
        check({tag, "_pkt_rdata"}, pkt_rdata,      32'd0);
        check({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
        check({tag, "_tx_data"},   tx_data,        32'd0);
        check({tag, "_tx_last"},   32'(tx_last),   32'd0);
    endtask

    // Stream one request packet in; stray reply strobes are thrown in and must be ignored.
    task automatic send_pkt(input logic [31:0] words [$], input bit gaps);
        int n;
        int sent;
        int budget;
        bit drop;
        n      = words.size();
        sent   = 0;
        budget = 0;
        drop   = (n > DEPTH);
        while (sent < n && budget < 200) begin
            budget++;
            check("fill_rx_ready", 32'(rx_ready), 32'd1);
            check("fill_pkt_rdy",  32'(pkt_rdy),  32'd0);
            check("fill_rx_drop",  32'(rx_drop),  32'd0);
            pkt_we    = ($urandom_range(0, 3) == 0);
            pkt_waddr = AW'($urandom);
            pkt_wdata = $urandom;
            pkt_done  = ($urandom_range(0, 5) == 0);
            if (gaps && $urandom_range(0, 3) == 0) begin
                rx_valid = 1'b0;
                rx_last  = 1'b0;
                rx_data  = $urandom;
            end else begin
                rx_valid = 1'b1;
                rx_data  = words[sent];
                rx_last  = (sent == n - 1);
                if (sent < DEPTH) m_rx[sent] = words[sent];
                sent++;
            end
            tick();
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        pkt_we   = 1'b0;
        pkt_done = 1'b0;
        check("fill_timeout",   32'(sent),     32'(n));
        check("end_pkt_rdy",    32'(pkt_rdy),  32'(!drop));
        check("end_rx_drop",    32'(rx_drop),  32'(drop));
        check("end_rx_ready",   32'(rx_ready), 32'(drop));
        check("end_pkt_busy",   32'(pkt_busy), 32'd0);
        if (!drop) begin
            m_len = 0;
        end else begin
            tick();
            check("drop_width",    32'(rx_drop),  32'd0);
            check("drop_no_rdy",   32'(pkt_rdy),  32'd0);
            check("drop_rx_ready", 32'(rx_ready), 32'd1);
        end
    endtask

    task automatic send_rand(input int n, input bit gaps);
        logic [31:0] q [$];
        q.delete();
        for (int i = 0; i < n; i++) q.push_back($urandom);
        send_pkt(q, gaps);
    endtask

    // Read one request word; data must appear one cycle later and not follow a later address change.
    task automatic read_chk(input int a);
        pkt_raddr = AW'(a);
        tick();
        check("pkt_rdata", pkt_rdata, m_rx[a]);
        pkt_raddr = AW'(~a);
        #1;
        check("pkt_rdata_hold", pkt_rdata, m_rx[a]);
    endtask

    task automatic wr_reply(input int addr, input logic [31:0] data);
        pkt_we    = 1'b1;
        pkt_waddr = AW'(addr);
        pkt_wdata = data;
        m_tx[addr]       = data;
        m_tx_known[addr] = 1'b1;
        if (addr + 1 > m_len) m_len = addr + 1;
        tick();
        pkt_we = 1'b0;
        check("reply_pkt_rdy",  32'(pkt_rdy),  32'd1);
        check("reply_pkt_busy", 32'(pkt_busy), 32'd0);
        check("reply_rx_ready", 32'(rx_ready), 32'd0);
    endtask

    task automatic do_done(input bit simult, input int addr, input logic [31:0] data);
        pkt_done = 1'b1;
        if (simult) begin
            pkt_we    = 1'b1;
            pkt_waddr = AW'(addr);
            pkt_wdata = data;
            m_tx[addr]       = data;
            m_tx_known[addr] = 1'b1;
            if (addr + 1 > m_len) m_len = addr + 1;
        end
        tick();
        pkt_done = 1'b0;
        pkt_we   = 1'b0;
    endtask

    function automatic logic pick_ready(input int mode, input bit tog);
        case (mode)
            0:       return 1'b1;
            1:       return tog;
            default: return ($urandom_range(0, 2) != 0);
        endcase
    endfunction

    // Drain the reply; called at the first sample after the pkt_done edge.
    task automatic drain(input int mode, input bit rst_mid);
        int idx;
        int budget;
        bit fired;
        bit tog;
        if (m_len == 0) begin
            check("zlen_tx_valid", 32'(tx_valid), 32'd0);
            check("zlen_busy",     32'(pkt_busy), 32'd0);
            check("zlen_pkt_rdy",  32'(pkt_rdy),  32'd0);
            check("zlen_rx_ready", 32'(rx_ready), 32'd1);
            tick();
            check("zlen_tx_valid2", 32'(tx_valid), 32'd0);
            return;
        end
        check("done_pkt_rdy",  32'(pkt_rdy),  32'd0);
        check("done_busy",     32'(pkt_busy), 32'd1);
        check("done_tx_valid", 32'(tx_valid), 32'd0);
        check("done_rx_ready", 32'(rx_ready), 32'd0);
        tog      = 1'b0;
        tx_ready = pick_ready(mode, tog);
        tick();
        idx    = 0;
        budget = 0;
        while (idx < m_len && budget < 400) begin
            budget++;
            check("drain_busy",     32'(pkt_busy), 32'd1);
            check("drain_tx_valid", 32'(tx_valid), 32'd1);
            check("drain_rx_ready", 32'(rx_ready), 32'd0);
            check("drain_pkt_rdy",  32'(pkt_rdy),  32'd0);
            if (m_tx_known[idx]) check("tx_data", tx_data, m_tx[idx]);
            check("tx_last", 32'(tx_last), 32'(idx == m_len - 1));
            tog       = !tog;
            tx_ready  = pick_ready(mode, tog);
            pkt_we    = ($urandom_range(0, 3) == 0);
            pkt_waddr = AW'($urandom);
            pkt_wdata = $urandom;
            pkt_done  = ($urandom_range(0, 3) == 0);
            fired     = tx_ready;
            tick();
            if (fired) idx++;
            if (rst_mid && idx == 1) begin
                tx_ready = 1'b0;
                pkt_we   = 1'b0;
                pkt_done = 1'b0;
                rst      = 1'b1;
                tick();
                check_all_zero("rst_mid");
                rst = 1'b0;
                tick();
                check("rst_mid_rx_ready", 32'(rx_ready), 32'd1);
                check("rst_mid_busy",     32'(pkt_busy), 32'd0);
                check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
                return;
            end
        end
        tx_ready = 1'b0;
        pkt_we   = 1'b0;
        pkt_done = 1'b0;
        check("drain_timeout",  32'(idx),      32'(m_len));
        check("post_tx_valid",  32'(tx_valid), 32'd0);
        check("post_busy",      32'(pkt_busy), 32'd0);
        check("post_tx_last",   32'(tx_last),  32'd0);
        check("post_rx_ready",  32'(rx_ready), 32'd1);
        check("post_pkt_rdy",   32'(pkt_rdy),  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q [$];
        n_vec     = 0;
        n_err     = 0;
        m_len     = 0;
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = '0;
        rx_last   = 1'b0;
        pkt_raddr = '0;
        pkt_we    = 1'b0;
        pkt_waddr = '0;
        pkt_wdata = '0;
        pkt_done  = 1'b0;
        tx_ready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_tx_known[i] = 1'b0;

        // Reset state.
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check("reset_rx_ready", 32'(rx_ready), 32'd1);

        // Basic round trip.
        q.delete();
        q.push_back(32'h2000_00F0);
        q.push_back(32'h2000_0F01);
        q.push_back(32'hCAFE_0001);
        send_pkt(q, 1'b0);
        read_chk(2);
        read_chk(0);
        wr_reply(0, 32'h0000_1111);
        wr_reply(1, 32'h0000_2222);
        do_done(1'b0, 0, 32'h0);
        drain(0, 1'b0);

        // Backpressure with tx_ready toggling.
        send_rand(1, 1'b0);
        read_chk(0);
        wr_reply(0, 32'h0000_1111);
        wr_reply(1, 32'h0000_2222);
        do_done(1'b0, 0, 32'h0);
        drain(1, 1'b0);

        // Full-depth packet and full-depth reply.
        send_rand(DEPTH, 1'b1);
        read_chk(DEPTH - 1);
        read_chk(5);
        for (int i = DEPTH - 1; i >= 0; i--) wr_reply(i, $urandom);
        do_done(1'b0, 0, 32'h0);
        drain(2, 1'b0);

        // Overflow, then a one-word packet, then a zero-length reply.
        send_rand(20, 1'b0);
        send_rand(1, 1'b0);
        read_chk(0);
        do_done(1'b0, 0, 32'h0);
        drain(0, 1'b0);

        // Reply write together with pkt_done.
        send_rand(2, 1'b0);
        do_done(1'b1, 3, 32'h0000_ABCD);
        drain(0, 1'b0);

        // Strobes in IDLE are ignored: word 0 of the next reply stays stale.
        pkt_we    = 1'b1;
        pkt_waddr = '0;
        pkt_wdata = 32'hDEAD_BEEF;
        pkt_done  = 1'b1;
        tick();
        pkt_we   = 1'b0;
        pkt_done = 1'b0;
        check("idle_strobe_busy",     32'(pkt_busy), 32'd0);
        check("idle_strobe_tx_valid", 32'(tx_valid), 32'd0);
        check("idle_strobe_pkt_rdy",  32'(pkt_rdy),  32'd0);
        check("idle_strobe_rx_ready", 32'(rx_ready), 32'd1);
        send_rand(1, 1'b0);
        wr_reply(1, 32'h0000_5555);
        do_done(1'b0, 0, 32'h0);
        drain(2, 1'b0);

        // Reset after the first transfer of a 4-word reply.
        send_rand(3, 1'b0);
        for (int i = 0; i < 4; i++) wr_reply(i, $urandom);
        do_done(1'b0, 0, 32'h0);
        drain(0, 1'b1);

        // Randomized packets and replies.
        for (int t = 0; t < 30; t++) begin
            int n;
            int nw;
            n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(17, 20)) : int'($urandom_range(1, 16));
            send_rand(n, 1'b1);
            if (n > DEPTH) continue;
            repeat (3) read_chk(int'($urandom_range(0, n - 1)));
            nw = int'($urandom_range(0, 5));
            for (int i = 0; i < nw; i++) begin
                if ($urandom_range(0, 2) == 0) tick();
                wr_reply(int'($urandom_range(0, DEPTH - 1)), $urandom);
            end
            if ($urandom_range(0, 3) == 0) do_done(1'b1, int'($urandom_range(0, DEPTH - 1)), $urandom);
            else                           do_done(1'b0, 0, 32'h0);
            drain(int'($urandom_range(0, 2)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
